// File: rtl/issue_queue_ctrl_if.sv
// Dispatch / issue-queue handshake bundle for issue_queue_ctrl.
// The master modport is the controller's view; the slave modport is the
// dispatch stage, queue and issue block seen together from outside.
interface issue_queue_ctrl_if #(
   parameter int PTR_WIDTH = 2
);
   logic                 flush;
   logic                 dispatch_valid;
   logic                 dispatch_stall;
   logic                 write_enable;
   logic [PTR_WIDTH-1:0] write_pointer;
   logic [PTR_WIDTH-1:0] read_pointer;
   logic                 queue_flush;
   logic                 issueque_ready;
   logic                 issueblk_done;
   logic                 issue_fire;
   logic [PTR_WIDTH:0]   queue_count;
   logic                 queue_full;
   logic                 queue_empty;

   modport master (
      input  flush, dispatch_valid, issueque_ready, issueblk_done,
      output dispatch_stall, write_enable, write_pointer, read_pointer,
             queue_flush, issue_fire, queue_count, queue_full, queue_empty
   );

   modport slave (
      output flush, dispatch_valid, issueque_ready, issueblk_done,
      input  dispatch_stall, write_enable, write_pointer, read_pointer,
             queue_flush, issue_fire, queue_count, queue_full, queue_empty
   );
endinterface

// File: rtl/issue_queue_ctrl.sv
// Pointer and occupancy controller for one in-order issue queue.
// Tracks head/tail pointers and occupancy, stalls dispatch when full, and
// sequences a multi-cycle flush recovery (RUN -> FLUSH -> RUN).
module issue_queue_ctrl #(
   parameter int DEPTH        = 4,
   parameter int PTR_WIDTH    = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   issue_queue_ctrl_if.master bus
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0]   FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]   count_q, count_d;
   logic [CNT_W-1:0]     fcnt_q, fcnt_d;

   logic full, empty, stall, wr_en, fire;

   // Handshake outputs: all derived from the registered state and this cycle's inputs.
   // Occupancy, not pointer equality, decides full vs empty.
   assign full  = (count_q == FULL_COUNT);
   assign empty = (count_q == '0);
   assign stall = bus.flush | (state_q == FLUSH) | full;
   assign wr_en = bus.dispatch_valid & ~stall;
   assign fire  = (state_q == RUN) & ~bus.flush & ~empty
                  & bus.issueque_ready & bus.issueblk_done;

   assign bus.queue_full     = full;
   assign bus.queue_empty    = empty;
   assign bus.dispatch_stall = stall;
   assign bus.write_enable   = wr_en;
   assign bus.issue_fire     = fire;
   assign bus.queue_flush    = bus.flush | (state_q == FLUSH);
   assign bus.write_pointer  = wr_ptr_q;
   assign bus.read_pointer   = rd_ptr_q;
   assign bus.queue_count    = count_q;

   // Next-state logic: flush wins over everything, FLUSH counts down, RUN moves pointers.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      fcnt_d   = fcnt_q;

      if (bus.flush) begin
         state_d  = FLUSH;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         fcnt_d   = FLUSH_LOAD;
      end else if (state_q == FLUSH) begin
         if (fcnt_q == '0) begin
            state_d = RUN;
         end else begin
            fcnt_d = fcnt_q - CNT_W'(1);
         end
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (wr_en) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
         if (fire)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
         unique case ({wr_en, fire})
            2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State register with asynchronous reset to an empty queue in RUN.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q  <= RUN;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         fcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         fcnt_q   <= fcnt_d;
      end
   end

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Directed self-checking bench for issue_queue_ctrl (DEPTH=4, FLUSH_CYCLES=2).
module tb_issue_queue_ctrl;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   issue_queue_ctrl_if #(.PTR_WIDTH(2)) bus ();

   issue_queue_ctrl #(
      .DEPTH        (4),
      .PTR_WIDTH    (2),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int exp_wp;
   int exp_rp;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      bus.flush          = 1'b0;
      bus.dispatch_valid = 1'b0;
      bus.issueque_ready = 1'b0;
      bus.issueblk_done  = 1'b0;
      #2;
      // Reset state
      check("rst_empty", bus.queue_empty, 1);
      check("rst_full",  bus.queue_full, 0);
      check("rst_stall", bus.dispatch_stall, 0);
      check("rst_we",    bus.write_enable, 0);
      check("rst_fire",  bus.issue_fire, 0);
      check("rst_qflush", bus.queue_flush, 0);
      check("rst_wp",    bus.write_pointer, 0);
      check("rst_rp",    bus.read_pointer, 0);
      check("rst_count", bus.queue_count, 0);
      tick();
      reset = 1'b0;
      #1;

      // 1. Fill to full
      bus.dispatch_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("fill_wp", bus.write_pointer, i);
         check("fill_we", bus.write_enable, 1);
         check("fill_stall", bus.dispatch_stall, 0);
         tick();
      end
      #1;
      check("full_wp", bus.write_pointer, 0);
      check("full_count", bus.queue_count, 4);
      check("full_flag", bus.queue_full, 1);
      check("full_stall", bus.dispatch_stall, 1);
      check("full_we", bus.write_enable, 0);
      tick();
      check("full_hold_count", bus.queue_count, 4);
      check("full_hold_wp", bus.write_pointer, 0);

      // 2. Drain to empty
      bus.dispatch_valid = 1'b0;
      bus.issueque_ready = 1'b1;
      bus.issueblk_done  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("drain_rp", bus.read_pointer, i);
         check("drain_fire", bus.issue_fire, 1);
         tick();
      end
      #1;
      check("drain_rp_wrap", bus.read_pointer, 0);
      check("drain_empty", bus.queue_empty, 1);
      // 5. Empty queue ignores ready/done
      check("empty_fire", bus.issue_fire, 0);
      tick();
      check("empty_rp_hold", bus.read_pointer, 0);
      check("empty_count", bus.queue_count, 0);

      // 3. Build count = 2, then simultaneous dispatch and issue for 6 cycles
      bus.issueque_ready = 1'b0;
      bus.dispatch_valid = 1'b1;
      tick();
      tick();
      check("pre3_count", bus.queue_count, 2);
      check("pre3_wp", bus.write_pointer, 2);
      bus.issueque_ready = 1'b1;
      exp_wp = 2;
      exp_rp = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("both_we", bus.write_enable, 1);
         check("both_fire", bus.issue_fire, 1);
         tick();
         exp_wp = (exp_wp + 1) % 4;
         exp_rp = (exp_rp + 1) % 4;
         check("both_count", bus.queue_count, 2);
         check("both_wp", bus.write_pointer, exp_wp);
         check("both_rp", bus.read_pointer, exp_rp);
      end

      // 4. Count = 3, flush pulse with dispatch_valid held
      bus.issueque_ready = 1'b0;
      tick();
      check("pre4_count", bus.queue_count, 3);
      bus.flush = 1'b1;
      #1;
      check("fl0_we", bus.write_enable, 0);
      check("fl0_stall", bus.dispatch_stall, 1);
      check("fl0_qflush", bus.queue_flush, 1);
      tick();
      bus.flush = 1'b0;
      #1;
      check("fl1_count", bus.queue_count, 0);
      check("fl1_wp", bus.write_pointer, 0);
      check("fl1_rp", bus.read_pointer, 0);
      check("fl1_qflush", bus.queue_flush, 1);
      check("fl1_we", bus.write_enable, 0);
      tick();
      check("fl2_qflush", bus.queue_flush, 1);
      check("fl2_we", bus.write_enable, 0);
      tick();
      check("fl3_qflush", bus.queue_flush, 0);
      check("fl3_we", bus.write_enable, 1);
      check("fl3_stall", bus.dispatch_stall, 0);
      tick();
      check("fl_first_wp", bus.write_pointer, 1);
      check("fl_first_count", bus.queue_count, 1);

      // 6. Asynchronous reset mid-cycle at count = 2, and again while in FLUSH
      tick();
      bus.dispatch_valid = 1'b0;
      check("pre6_count", bus.queue_count, 2);
      reset = 1'b1;
      #1;
      check("arst_count", bus.queue_count, 0);
      check("arst_wp", bus.write_pointer, 0);
      check("arst_empty", bus.queue_empty, 1);
      #1;
      reset = 1'b0;
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      #1;
      check("pre6b_qflush", bus.queue_flush, 1);
      reset = 1'b1;
      #1;
      check("arst_fl_qflush", bus.queue_flush, 0);
      check("arst_fl_stall", bus.dispatch_stall, 0);
      #1;
      reset = 1'b0;
      tick();
      check("post_rst_qflush", bus.queue_flush, 0);
      check("post_rst_count", bus.queue_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
